// File: rtl/wb_retire_pkg.sv
// Shared RV32I types for the write-back/retire stage: load funct3 codes,
// result-source enumeration and the control word carried down the pipe.
package rv32i_types;

  localparam int SRC_SEL_W = 3;

  typedef enum logic [2:0] {
    F3_LB  = 3'd0,
    F3_LH  = 3'd1,
    F3_LW  = 3'd2,
    F3_LBU = 3'd4,
    F3_LHU = 3'd5
  } load_funct3_e;

  typedef enum logic [SRC_SEL_W-1:0] {
    SRC_ALU   = 3'd0,
    SRC_LUI   = 3'd1,
    SRC_AUIPC = 3'd2,
    SRC_PC4   = 3'd3
  } src_sel_e;

  typedef struct packed {
    logic       regwrite;
    logic [4:0] rd;
    logic       is_load;
    logic [2:0] funct3;
    src_sel_e   src_sel;
  } rv32i_control_word;

endpackage

// File: rtl/wb_retire_if.sv
// MEM-stage to write-back handshake bundle.
interface wb_retire_if #(
  parameter int XLEN = 32,
  parameter int NSRC = 4
);
  import rv32i_types::*;

  logic                           in_valid;
  logic                           in_ready;
  rv32i_control_word              in_ctrl;
  logic [NSRC-1:0][XLEN-1:0]      in_src;
  logic [XLEN-1:0]                in_mem_rdata;
  logic [1:0]                     in_addr_lo;

  modport master (
    output in_valid, in_ctrl, in_src, in_mem_rdata, in_addr_lo,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_ctrl, in_src, in_mem_rdata, in_addr_lo,
    output in_ready
  );
endinterface

// File: rtl/wb_retire_load_align.sv
// Extracts the addressed byte/half/word from an aligned memory word and
// flags loads whose offset or encoding is not legal.
module load_align
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o,
  output logic            misalign_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_w = rdata_i[7:0];
      2'd1:    byte_w = rdata_i[15:8];
      2'd2:    byte_w = rdata_i[23:16];
      default: byte_w = rdata_i[31:24];
    endcase
    half_w = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o     = rdata_i;
    misalign_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(XLEN-8){byte_w[7]}}, byte_w};
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_w};
      F3_LH: begin
        data_o     = {{(XLEN-16){half_w[15]}}, half_w};
        misalign_o = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o     = {{(XLEN-16){1'b0}}, half_w};
        misalign_o = addr_lo_i[0];
      end
      F3_LW:   misalign_o = (addr_lo_i != 2'b00);
      // 3, 6 and 7 are not loads in RV32I
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_retire_src_mux.sv
// Generic N-way result selector; out-of-range selects fall back to entry 0.
module src_mux #(
  parameter int NSRC  = 4,
  parameter int XLEN  = 32,
  parameter int SEL_W = 3
) (
  input  logic [NSRC-1:0][XLEN-1:0] src_i,
  input  logic [SEL_W-1:0]          sel_i,
  output logic [XLEN-1:0]           y_o
);

  always_comb begin
    y_o = src_i[0];
    for (int i = 1; i < NSRC; i++) begin
      if (sel_i == SEL_W'(i)) y_o = src_i[i];
    end
  end

endmodule

// File: rtl/wb_retire.sv
// Write-back/retire stage: one-cycle registered register-file write port,
// misaligned-load pulse and retired-instruction counter.
module wb_retire
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int NSRC  = 4,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  wb_retire_if.slave       bus,
  input  logic             hold,
  input  logic             flush,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             load_misalign,
  output logic [CNT_W-1:0] instret
);

  logic             accept;
  logic             ld_mis;
  logic             misaligned;
  logic [XLEN-1:0]  ld_data;
  logic [XLEN-1:0]  src_res;
  logic [XLEN-1:0]  result;

  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3_i   (bus.in_ctrl.funct3),
    .addr_lo_i  (bus.in_addr_lo),
    .rdata_i    (bus.in_mem_rdata),
    .data_o     (ld_data),
    .misalign_o (ld_mis)
  );

  src_mux #(.NSRC(NSRC), .XLEN(XLEN), .SEL_W(SRC_SEL_W)) u_src_mux (
    .src_i (bus.in_src),
    .sel_i (bus.in_ctrl.src_sel),
    .y_o   (src_res)
  );

  assign bus.in_ready = rst & ~hold;
  assign accept       = bus.in_valid & bus.in_ready & ~flush;
  assign misaligned   = bus.in_ctrl.is_load & ld_mis;
  assign result       = bus.in_ctrl.is_load ? ld_data : src_res;

  always_comb begin
    rf_we_d    = rf_we_q;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    mis_d      = mis_q;
    instret_d  = instret_q + CNT_W'(accept);
    // hold freezes the whole output register, pulses included
    if (!hold) begin
      rf_we_d = accept & bus.in_ctrl.regwrite & (bus.in_ctrl.rd != 5'd0) & ~misaligned;
      mis_d   = accept & misaligned;
      if (accept) begin
        rf_rd_d    = bus.in_ctrl.rd;
        rf_wdata_d = result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= '0;
      mis_q      <= 1'b0;
      instret_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      mis_q      <= mis_d;
      instret_q  <= instret_d;
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_rd         = rf_rd_q;
  assign rf_wdata      = rf_wdata_q;
  assign load_misalign = mis_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_wb_retire.sv
// Scoreboard bench for wb_retire; a 3-bit-counter twin exercises instret wrap.
module tb_wb_retire;
  import rv32i_types::*;

  logic clk;
  logic rst;
  logic hold;
  logic flush;

  logic        rf_we, load_misalign;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [63:0] instret;

  logic        rf_we_s, mis_s;
  logic [4:0]  rf_rd_s;
  logic [31:0] rf_wdata_s;
  logic [2:0]  instret_s;

  wb_retire_if #(.XLEN(32), .NSRC(4)) bus ();
  wb_retire_if #(.XLEN(32), .NSRC(4)) bus_s ();

  assign bus_s.in_valid     = bus.in_valid;
  assign bus_s.in_ctrl      = bus.in_ctrl;
  assign bus_s.in_src       = bus.in_src;
  assign bus_s.in_mem_rdata = bus.in_mem_rdata;
  assign bus_s.in_addr_lo   = bus.in_addr_lo;

  wb_retire #(.XLEN(32), .NSRC(4), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hold(hold), .flush(flush),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .load_misalign(load_misalign), .instret(instret)
  );

  wb_retire #(.XLEN(32), .NSRC(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s), .hold(hold), .flush(flush),
    .rf_we(rf_we_s), .rf_rd(rf_rd_s), .rf_wdata(rf_wdata_s),
    .load_misalign(mis_s), .instret(instret_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tgt;
    string       nm;
    bit          we;
    bit          mis;
    bit          chk_rd;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [63:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every expectation due in the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tgt <= cyc) begin
        e = q.pop_front();
        chk({e.nm, ".late"}, 64'(cyc - e.tgt), 64'd0);
        chk({e.nm, ".rf_we"}, {63'd0, rf_we}, {63'd0, e.we});
        chk({e.nm, ".misalign"}, {63'd0, load_misalign}, {63'd0, e.mis});
        chk({e.nm, ".instret"}, instret, e.cnt);
        chk({e.nm, ".instret_w3"}, {61'd0, instret_s}, {61'd0, e.cnt[2:0]});
        if (e.chk_rd) begin
          chk({e.nm, ".rf_rd"}, {59'd0, rf_rd}, {59'd0, e.rd});
          chk({e.nm, ".rf_wdata"}, {32'd0, rf_wdata}, {32'd0, e.wd});
        end
      end
    end
  end

  task automatic drive(input bit v, input bit rw, input logic [4:0] rd, input bit ld,
                       input logic [2:0] f3, input logic [2:0] sel, input logic [1:0] alo);
    rv32i_control_word c;
    c.regwrite = rw;
    c.rd       = rd;
    c.is_load  = ld;
    c.funct3   = f3;
    c.src_sel  = src_sel_e'(sel);
    bus.in_ctrl    = c;
    bus.in_valid   = v;
    bus.in_addr_lo = alo;
  endtask

  task automatic step(input string nm, input bit v, input bit fl, input bit hd,
                      input bit rw, input logic [4:0] rd, input bit ld,
                      input logic [2:0] f3, input logic [2:0] sel, input logic [1:0] alo,
                      input bit e_we, input bit e_mis, input logic [31:0] e_wd);
    bit acc;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    hold  = hd;
    flush = fl;
    drive(v, rw, rd, ld, f3, sel, alo);
    #1;
    chk({nm, ".in_ready"}, {63'd0, bus.in_ready}, {63'd0, ~hd});
    acc = v & ~hd & ~fl;
    if (!hd) begin
      last.we  = acc & e_we;
      last.mis = acc & e_mis;
      if (acc) begin
        last.cnt    = last.cnt + 64'd1;
        last.chk_rd = e_we;
        last.rd     = rd;
        last.wd     = e_wd;
      end
    end
    last.tgt = cyc + 1;
    last.nm  = nm;
    q.push_back(last);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    hold  = 1'b1;
    flush = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 1'b1, 3'd2, 3'd0, 2'd0);
    #1;
    chk({nm, ".in_ready"}, {63'd0, bus.in_ready}, 64'd0);
    last.we     = 1'b0;
    last.mis    = 1'b0;
    last.chk_rd = 1'b1;
    last.rd     = 5'd0;
    last.wd     = 32'd0;
    last.cnt    = 64'd0;
    last.tgt    = cyc + 1;
    last.nm     = nm;
    q.push_back(last);
  endtask

  initial begin
    rst   = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    bus.in_mem_rdata = 32'h8070_F0A5;
    bus.in_src = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_1234};
    drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 3'd0, 2'd0);
    repeat (2) @(posedge clk);
    do_reset("rst_init");

    //    name        v  fl hd rw rd     ld f3    sel   alo   we mis data
    step("lb_a2",     1, 0, 0, 1, 5'd5,  1, 3'd0, 3'd0, 2'd2, 1, 0, 32'h0000_0070);
    step("lb_a0",     1, 0, 0, 1, 5'd5,  1, 3'd0, 3'd0, 2'd0, 1, 0, 32'hFFFF_FFA5);
    step("lb_a1",     1, 0, 0, 1, 5'd6,  1, 3'd0, 3'd0, 2'd1, 1, 0, 32'hFFFF_FFF0);
    step("lb_a3",     1, 0, 0, 1, 5'd6,  1, 3'd0, 3'd0, 2'd3, 1, 0, 32'hFFFF_FF80);
    step("lbu_a0",    1, 0, 0, 1, 5'd7,  1, 3'd4, 3'd0, 2'd0, 1, 0, 32'h0000_00A5);
    step("lbu_a3",    1, 0, 0, 1, 5'd7,  1, 3'd4, 3'd0, 2'd3, 1, 0, 32'h0000_0080);
    step("lhu_a2",    1, 0, 0, 1, 5'd7,  1, 3'd5, 3'd0, 2'd2, 1, 0, 32'h0000_8070);
    step("lh_a2",     1, 0, 0, 1, 5'd8,  1, 3'd1, 3'd0, 2'd2, 1, 0, 32'hFFFF_8070);
    step("lh_a0",     1, 0, 0, 1, 5'd8,  1, 3'd1, 3'd0, 2'd0, 1, 0, 32'hFFFF_F0A5);
    step("lhu_a0",    1, 0, 0, 1, 5'd8,  1, 3'd5, 3'd0, 2'd0, 1, 0, 32'h0000_F0A5);
    step("lh_a1",     1, 0, 0, 1, 5'd9,  1, 3'd1, 3'd0, 2'd1, 0, 1, 32'h0);
    step("idle_mis",  0, 0, 0, 0, 5'd0,  0, 3'd0, 3'd0, 2'd0, 0, 0, 32'h0);
    step("lw_a0",     1, 0, 0, 1, 5'd9,  1, 3'd2, 3'd0, 2'd0, 1, 0, 32'h8070_F0A5);
    step("lw_a2",     1, 0, 0, 1, 5'd9,  1, 3'd2, 3'd0, 2'd2, 0, 1, 32'h0);
    step("f3_3",      1, 0, 0, 1, 5'd9,  1, 3'd3, 3'd0, 2'd0, 0, 1, 32'h0);
    step("f3_6",      1, 0, 0, 1, 5'd9,  1, 3'd6, 3'd0, 2'd0, 0, 1, 32'h0);
    step("f3_7",      1, 0, 0, 1, 5'd9,  1, 3'd7, 3'd0, 2'd0, 0, 1, 32'h0);
    step("lhu_a3",    1, 0, 0, 1, 5'd9,  1, 3'd5, 3'd0, 2'd3, 0, 1, 32'h0);
    step("lw_rd0",    1, 0, 0, 1, 5'd0,  1, 3'd2, 3'd0, 2'd0, 0, 0, 32'h0);
    step("alu_rd0",   1, 0, 0, 1, 5'd0,  0, 3'd0, 3'd0, 2'd0, 0, 0, 32'h0);
    step("sel0",      1, 0, 0, 1, 5'd3,  0, 3'd0, 3'd0, 2'd0, 1, 0, 32'h0000_1234);
    step("sel1",      1, 0, 0, 1, 5'd4,  0, 3'd0, 3'd1, 2'd0, 1, 0, 32'h1111_0001);
    step("sel2",      1, 0, 0, 1, 5'd4,  0, 3'd0, 3'd2, 2'd0, 1, 0, 32'h2222_0002);
    step("sel3",      1, 0, 0, 1, 5'd4,  0, 3'd0, 3'd3, 2'd0, 1, 0, 32'h3333_0003);
    step("sel5",      1, 0, 0, 1, 5'd4,  0, 3'd0, 3'd5, 2'd0, 1, 0, 32'h0000_1234);
    step("sel7",      1, 0, 0, 1, 5'd4,  0, 3'd0, 3'd7, 2'd0, 1, 0, 32'h0000_1234);
    step("no_rw",     1, 0, 0, 0, 5'd4,  0, 3'd0, 3'd1, 2'd0, 0, 0, 32'h0);
    step("acc_n",     1, 0, 0, 1, 5'd8,  0, 3'd0, 3'd2, 2'd0, 1, 0, 32'h2222_0002);
    for (int i = 0; i < 3; i++)
      step("hold",    1, 0, 1, 1, 5'd10, 0, 3'd0, 3'd3, 2'd0, 0, 0, 32'h0);
    step("hold_flush",1, 1, 1, 1, 5'd10, 0, 3'd0, 3'd3, 2'd0, 0, 0, 32'h0);
    step("idle",      0, 0, 0, 1, 5'd10, 0, 3'd0, 3'd3, 2'd0, 0, 0, 32'h0);
    step("flush",     1, 1, 0, 1, 5'd11, 0, 3'd0, 3'd3, 2'd0, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++)
      step("wrap",    1, 0, 0, 1, 5'd12, 0, 3'd0, 3'd3, 2'd0, 1, 0, 32'h3333_0003);
    step("pre_rst",   1, 0, 0, 1, 5'd13, 0, 3'd0, 3'd1, 2'd0, 1, 0, 32'h1111_0001);
    do_reset("rst_mid");
    step("post_rst",  1, 0, 0, 1, 5'd1,  0, 3'd0, 3'd0, 2'd0, 1, 0, 32'h0000_1234);
    step("tail",      0, 0, 0, 0, 5'd0,  0, 3'd0, 3'd0, 2'd0, 0, 0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_retire.md
WB_RETIRE -- requirements
Module: wb_retire

Interface
REQ-001 Parameter XLEN, default 32: datapath width in bits; only 32 is legal.
REQ-002 Parameter NSRC, default 4: number of non-load result sources (ALU, LUI, AUIPC, PC+4).
REQ-003 Parameter CNT_W, default 64: width of the retired-instruction counter.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-006 in_valid  in  1  upstream (MEM stage) holds a valid instruction.
REQ-007 in_ready  out  1  stage can accept this cycle.
REQ-008 in_ctrl  in  rv32i_control_word  fields used: regwrite, rd[4:0], is_load, funct3[2:0], src_sel.
REQ-009 in_src  in  NSRC x XLEN  candidate results, indexed by in_ctrl.src_sel.
REQ-010 in_mem_rdata  in  XLEN  raw aligned data-memory word.
REQ-011 in_addr_lo  in  2  byte offset of the load address.
REQ-012 hold  in  1  downstream stall; freezes the output register.
REQ-013 flush  in  1  kill the instruction presented this cycle.
REQ-014 rf_we / rf_rd / rf_wdata  out  1 / 5 / XLEN  registered register-file write port, also the forwarding source.
REQ-015 load_misalign  out  1  one-cycle pulse registered with the offending instruction.
REQ-016 instret  out  CNT_W  count of retired instructions.

Function
REQ-017 Accept = in_valid & in_ready & ~flush; in_ready = ~hold.
REQ-018 Latency is exactly 1 cycle: an accepted instruction drives rf_* on the next cycle.
REQ-019 Non-load result = in_src[src_sel]; a src_sel >= NSRC selects in_src[0].
REQ-020 Load extraction: LB/LBU take byte in_addr_lo, LH/LHU take half in_addr_lo[1], LW takes the full word; LB/LH sign-extend, LBU/LHU zero-extend to XLEN.
REQ-021 Misaligned: LH/LHU with in_addr_lo[0]=1, LW with in_addr_lo!=0, any funct3 in {3,6,7} -> load_misalign=1 and rf_we=0 for that instruction.
REQ-022 rf_we = accepted & regwrite & (rd!=0) & ~misaligned; rd=0 never writes.
REQ-023 Cycle with no acceptance and hold=0: rf_we=0, load_misalign=0, rf_rd/rf_wdata keep their previous values.
REQ-024 hold=1: rf_we, rf_rd, rf_wdata, load_misalign keep their previous values; no input is consumed.
REQ-025 flush with in_valid=1: instruction is dropped, not counted, and produces no write or misalign pulse.
REQ-026 instret increments by 1 on each accepted instruction, misaligned loads included, and wraps from 2^CNT_W-1 to 0.
REQ-027 hold and flush in the same cycle: hold governs the output, flush drops the input, and instret is unchanged.

Reset
REQ-028 With rst=0 at a clk edge: rf_we=0, rf_rd=0, rf_wdata=0, load_misalign=0, instret=0.
REQ-029 Reset overrides hold, flush and in_valid; an instruction presented during reset is discarded.
REQ-030 in_ready is 0 while rst=0.

Structure
REQ-031 The load funct3 encodings, src_sel enumeration, and new rv32i_control_word fields go in rv32i_types.
REQ-032 Load extraction and sign-extension are a combinational sub-module named load_align.
REQ-033 The source-select mux is generic, parameterised by NSRC and XLEN.

Verification
REQ-034 LB, mem=0x8070_F0A5, addr_lo=2, rd=5 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x0000_0070; repeat with addr_lo=0 -> 0xFFFF_FFA5.
REQ-035 LHU, mem=0x8070_F0A5, addr_lo=2 -> rf_wdata=0x0000_8070; LH with addr_lo=1 -> load_misalign=1, rf_we=0, instret+1.
REQ-036 ALU op, src_sel=0, rd=0, value 0x1234 -> rf_we=0, instret+1.
REQ-037 Accept at cycle N, hold=1 for cycles N+1..N+3 -> rf_* stable across all three cycles, in_ready=0.
REQ-038 in_valid=1 and flush=1 -> no write, instret unchanged; preload instret=2^CNT_W-1 then retire one -> instret=0.
REQ-039 rst=0 mid-stream for one cycle after rf_we=1 -> next cycle all outputs 0.
